// File: rtl/fir_chan_sched.sv
// Channel scheduler for a shared, time-multiplexed FIR MAC engine: writes one beat
// into the per-channel delay lines and runs one compute job per channel every DECIM beats.
//
//  state | meaning
//  IDLE  | ready for the next input beat
//  WRITE | streaming the latched beat into the engine, one channel per cycle
//  START | one-cycle start pulse for the job on r_ch
//  WAIT  | waiting for the engine to finish the job on r_ch
module fir_chan_sched #(
  parameter  int CHANNELS   = 16,
  parameter  int DATA_WIDTH = 16,
  parameter  int DECIM      = 8,
  localparam int CH_W       = $clog2(CHANNELS),
  localparam int PH_W       = $clog2(DECIM)
) (
  input  logic                           i_clk,
  input  logic                           i_nrst,
  input  logic                           i_s_tvalid,
  output logic                           o_s_tready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_s_tdata,
  input  logic                           i_phase_clr,
  output logic                           o_eng_wr_en,
  output logic [CH_W-1:0]                o_eng_wr_ch,
  output logic [DATA_WIDTH-1:0]          o_eng_wr_data,
  output logic                           o_eng_start,
  output logic [CH_W-1:0]                o_eng_ch,
  input  logic                           i_eng_done,
  output logic [PH_W-1:0]                o_phase,
  output logic                           o_err_spurious
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(DECIM - 1);

  state_t                r_state;
  state_t                w_next;
  logic [CH_W-1:0]       r_ch;
  logic [PH_W-1:0]       r_phase;
  logic                  r_tready;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_buf [CHANNELS];
  logic                  w_accept;
  logic                  w_last_ch;

  always_comb begin
    w_accept  = (r_state == S_IDLE) && i_s_tvalid && r_tready;
    w_last_ch = (r_ch == LAST_CH);
    w_next    = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_WRITE;
      S_WRITE: if (w_last_ch) w_next = (r_phase == LAST_PH) ? S_START : S_IDLE;
      S_START: w_next = S_WAIT;
      S_WAIT:  if (i_eng_done) w_next = w_last_ch ? S_IDLE : S_START;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state  <= S_IDLE;
      r_ch     <= '0;
      r_phase  <= '0;
      r_tready <= 1'b0;
      r_err    <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) r_buf[k] <= '0;
    end else begin
      r_state  <= w_next;
      // Registered ready: asserted exactly when the FSM will be in IDLE next cycle.
      r_tready <= (w_next == S_IDLE);
      if (i_eng_done && (r_state != S_WAIT)) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_phase_clr) r_phase <= '0;
          if (w_accept) begin
            r_ch <= '0;
            for (int k = 0; k < CHANNELS; k++)
              r_buf[k] <= i_s_tdata[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        S_WRITE: begin
          if (w_last_ch) begin
            r_ch    <= '0;
            r_phase <= (r_phase == LAST_PH) ? '0 : r_phase + PH_W'(1);
          end else begin
            r_ch <= r_ch + CH_W'(1);
          end
        end
        S_WAIT: begin
          if (i_eng_done) r_ch <= w_last_ch ? '0 : r_ch + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_s_tready     = r_tready;
  assign o_eng_wr_en    = (r_state == S_WRITE);
  assign o_eng_wr_ch    = r_ch;
  assign o_eng_wr_data  = r_buf[r_ch];
  assign o_eng_start    = (r_state == S_START);
  assign o_eng_ch       = r_ch;
  assign o_phase        = r_phase;
  assign o_err_spurious = r_err;

endmodule
